// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle sequencer.
//   - opcode / funct constants of the supported instruction subset
//   - next-PC select codes (shared with the IFU's op encoding)
//   - FSM state encodings and decoded instruction classes
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_B   = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // Unknown opcodes fold into CLS_NOP so they retire in DECODE like a nop.
  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_ALU = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_J   = 3'd5,
    CLS_JAL = 3'd6,
    CLS_JR  = 3'd7
  } instr_cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   instr  in  32  IR contents
//   cls    out     instruction class (instr_cls_t)
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output instr_cls_t  cls
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    cls = CLS_NOP;
    if (instr != 32'd0) begin
      case (opcode)
        OP_R: begin
          if (funct == FN_ADDU || funct == FN_SUBU) cls = CLS_ALU;
          else if (funct == FN_JR)                   cls = CLS_JR;
          else                                       cls = CLS_NOP;
        end
        OP_ORI, OP_LUI: cls = CLS_ALU;
        OP_LW:          cls = CLS_LW;
        OP_SW:          cls = CLS_SW;
        OP_BEQ:         cls = CLS_BEQ;
        OP_J:           cls = CLS_J;
        OP_JAL:         cls = CLS_JAL;
        default:        cls = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the IFU
// and datapath enables. Exactly one pc_en pulse per retired instruction.
//
// Optional feature macro: MC_PERF_CNT_EN (cycle / retired counters).
// Without it cyc_cnt and ret_cnt read 0 and no counter flops exist.
//
// Parameters:
//   FETCH_WAIT  extra stall cycles in FETCH (0..15)
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   instr    in   registered IR contents, stable from DECODE until retire
//   zero     in   ALU equality flag, used by beq in EXEC
//   pc_en    out  PC update strobe (retiring cycle)
//   npc_op   out  next-PC select (NPC_* codes)
//   ir_en    out  IR load strobe (last FETCH cycle)
//   grf_we   out  register-file write enable
//   dm_we    out  data-memory write enable
//   state    out  current FSM state (debug)
//   cyc_cnt  out  cycle counter
//   ret_cnt  out  retired-instruction counter
//
// state  | meaning
// FETCH  | wait for instruction memory, load IR on last cycle
// DECODE | classify; nop/unknown retires here
// EXEC   | ALU op; beq/j/jr retire here
// MEM    | data access; sw retires here
// WB     | register write-back; ALU/lw/jal retire here
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        pc_en,
  output logic [2:0]  npc_op,
  output logic        ir_en,
  output logic        grf_we,
  output logic        dm_we,
  output logic [2:0]  state,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);

  localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  instr_cls_t cls;

  mc_decode u_decode (
    .instr (instr),
    .cls   (cls)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pc_en   = 1'b0;
    npc_op  = NPC_SEQ;
    ir_en   = 1'b0;
    grf_we  = 1'b0;
    dm_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (wait_q == WAIT_LAST) begin
          ir_en   = 1'b1;
          wait_d  = 4'd0;
          state_d = ST_DECODE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_NOP) begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALU, CLS_JAL: state_d = ST_WB;
          CLS_LW, CLS_SW:   state_d = ST_MEM;
          CLS_BEQ: begin
            pc_en   = 1'b1;
            npc_op  = zero ? NPC_B : NPC_SEQ;
            state_d = ST_FETCH;
          end
          CLS_J: begin
            pc_en   = 1'b1;
            npc_op  = NPC_J;
            state_d = ST_FETCH;
          end
          CLS_JR: begin
            pc_en   = 1'b1;
            npc_op  = NPC_JR;
            state_d = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (cls == CLS_SW) begin
          dm_we   = 1'b1;
          pc_en   = 1'b1;
          state_d = ST_FETCH;
        end else if (cls == CLS_LW) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        grf_we  = 1'b1;
        pc_en   = 1'b1;
        npc_op  = (cls == CLS_JAL) ? NPC_J : NPC_SEQ;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Reset aborts the in-flight instruction: nothing may fire this cycle.
    if (rst) begin
      pc_en  = 1'b0;
      npc_op = NPC_SEQ;
      ir_en  = 1'b0;
      grf_we = 1'b0;
      dm_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state = rst ? ST_FETCH : state_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + 32'd1;
    ret_cnt_d = ret_cnt_q + {31'd0, pc_en};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= 32'd0;
      ret_cnt_q <= 32'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  assign cyc_cnt = 32'd0;
  assign ret_cnt = 32'd0;
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle sequencer for the instruction-fetch unit and datapath.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives the IFU's PC enable and next-PC select, plus IR, register-file and data-memory write enables.
- Sits between the IFU/IR and the datapath. Exactly one PC update per retired instruction.

Parameters:
- FETCH_WAIT, 0, extra stall cycles held in FETCH for slow instruction memory (0..15).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- instr  in  32  current IR contents (decoded opcode/funct).
- zero  in  1  ALU equality flag for beq, valid in EXEC.
- pc_en  out  1  IFU PC update strobe.
- npc_op  out  3  IFU next-PC select: NPC_SEQ=0, NPC_B=1, NPC_J=2, NPC_JR=3.
- ir_en  out  1  latch IFU instruction into IR.
- grf_we  out  1  register-file write enable.
- dm_we  out  1  data-memory write enable.
- state  out  3  current FSM state (debug).
- cyc_cnt  out  32  cycle counter (optional feature).
- ret_cnt  out  32  retired-instruction counter (optional feature).

Behaviour:
- Reset: clk and rst are single-clock; rst is synchronous and active-high. While rst=1 on a posedge: state<=FETCH, wait counter<=0, counters<=0. All enable outputs read 0 during any cycle with rst=1; npc_op=0; state=FETCH (0).
- Encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH:
  - Holds FETCH_WAIT extra cycles via a 4-bit counter.
  - ir_en=1 only in the final FETCH cycle, then go to DECODE.
  - With FETCH_WAIT=0, FETCH lasts exactly 1 cycle.
- DECODE: classify instr; always go to EXEC. Exception: nop (instr==0) or unknown opcode retires here with pc_en=1, npc_op=SEQ, then go to FETCH.
- EXEC:
  - R-type addu/subu, ori, lui, jal -> WB.
  - lw, sw -> MEM.
  - beq: retire; pc_en=1; npc_op = zero ? NPC_B : NPC_SEQ.
  - j: retire; pc_en=1, npc_op=NPC_J.
  - jr (funct 0x08): retire; pc_en=1, npc_op=NPC_JR.
- MEM:
  - sw: dm_we=1, pc_en=1, npc_op=SEQ; retire to FETCH.
  - lw: go to WB.
- WB:
  - grf_we=1, pc_en=1, retire to FETCH.
  - npc_op=NPC_J for jal; SEQ otherwise.
  - The link value is produced by the datapath.
- Latency per instruction, excluding FETCH_WAIT: nop 2; beq/j/jr 3; ALU/jal/sw 4; lw 5.
- Invariants:
  - pc_en high exactly 1 cycle per instruction, always in the retiring cycle.
  - grf_we and dm_we are never both high.
  - ir_en is never high in the same cycle as pc_en.
- Outputs are combinational from state plus the registered IR; instr must be stable from DECODE until retire.
- rst asserted mid-instruction aborts it: no enable fires in the rst cycle, and fetch restarts.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - cyc_cnt increments every non-reset cycle.
  - ret_cnt increments on every cycle with pc_en=1.
  - Both wrap modulo 2^32.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Shared package/def header holds: opcode/funct constants (R=0x00, ORI=0x0d, LUI=0x0f, LW=0x23, SW=0x2b, BEQ=0x04, J=0x02, JAL=0x03, ADDU=0x21, SUBU=0x23, JR=0x08), NPC_* codes (must match the IFU's op encoding), and state encodings.
- One natural sub-module, mc_decode: combinational instr -> instruction class (NOP, ALU, LW, SW, BEQ, J, JAL, JR).

Test Plan:
- rst=1 for 2 cycles then release, instr=0x00221821 (addu), FETCH_WAIT=0 -> states 0,1,2,4; grf_we=1 and pc_en=1 with npc_op=0 on the 4th cycle; ret_cnt=1.
- lw 0x8c020004 -> states 0,1,2,3,4; grf_we only in WB; pc_en once. Then sw 0xac020004 -> dm_we=1 and pc_en=1 in MEM, grf_we=0 throughout.
- beq 0x10210003: zero=1 -> EXEC gives pc_en=1, npc_op=1. Repeat with zero=0 -> npc_op=0; no grf_we/dm_we either way.
- jal 0x0c000c00 -> WB gives grf_we=1, npc_op=2. jr 0x03e00008 -> EXEC gives npc_op=3, pc_en=1.
- FETCH_WAIT=3 with instr=0 -> FETCH lasts 4 cycles, ir_en only on the 4th; nop retires in DECODE.
- rst pulsed during MEM of sw -> dm_we=0 and pc_en=0 that cycle; next state FETCH; counters reset to 0.
